dlx_latency_mem: RTL and testbench

// Synthesizable, parametrised data/instruction memory for the DLX, next generation of the tb memory models.

---
 rtl/dlx_latency_mem.sv | 128 ++++++++++++
 tb/tb_dlx_latency_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_latency_mem.sv
// Single-port DLX data/instruction memory with programmable access latency,
// byte-lane write masks and an ERROR response for misaligned or out-of-range addresses.
module dlx_latency_mem #(
  parameter int    WORD_SIZE    = 32,
  parameter int    ADDRESS_SIZE = 32,
  parameter int    DEPTH_LOG2   = 10,
  parameter int    DATA_DELAY   = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    readnotwrite_i,
  input  logic [ADDRESS_SIZE-1:0] address_i,
  input  logic [WORD_SIZE-1:0]    write_data_i,
  input  logic [WORD_SIZE/8-1:0]  byte_en_i,
  output logic                    data_ready_o,
  output logic [WORD_SIZE-1:0]    read_data_o,
  output logic                    error_o,
  output logic                    busy_o
);

  localparam int NB    = WORD_SIZE / 8;
  localparam int L     = $clog2(NB);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ADDRESS_SIZE'((1 << L) - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic                    rnw_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic [NB-1:0]           be_q;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic [WORD_SIZE-1:0]    mem_q [DEPTH];

  logic [ADDRESS_SIZE-1:0] req_addr;
  logic                    req_rnw;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic [NB-1:0]           req_be;
  logic                    req_err;
  logic                    lat_err;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    do_access;

  // With DATA_DELAY=1 the array is accessed on the accepting edge itself, before
  // the request registers hold anything, so the live inputs stand in for them.
  always_comb begin
    if (state_q == IDLE) begin
      req_addr  = address_i;
      req_rnw   = readnotwrite_i;
      req_wdata = write_data_i;
      req_be    = byte_en_i;
    end else begin
      req_addr  = addr_q;
      req_rnw   = rnw_q;
      req_wdata = wdata_q;
      req_be    = be_q;
    end
  end

  assign req_err   = (|(req_addr & ALIGN_MASK)) || ((req_addr >> (DEPTH_LOG2 + L)) != '0);
  assign lat_err   = (|(addr_q & ALIGN_MASK)) || ((addr_q >> (DEPTH_LOG2 + L)) != '0);
  assign req_idx   = req_addr[DEPTH_LOG2+L-1:L];
  assign do_access = (state_d == DONE) && (state_q != DONE) && !rst_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_access) begin
        if (req_err)      rdata_q <= '0;
        else if (req_rnw) rdata_q <= mem_q[req_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && enable_i) begin
      addr_q  <= address_i;
      rnw_q   <= readnotwrite_i;
      wdata_q <= write_data_i;
      be_q    <= byte_en_i;
    end
  end

  // NOTE: the storage array has no reset; contents survive RST and only writes change them.
  always_ff @(posedge clk_i) begin
    if (do_access && !req_rnw && !req_err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (enable_i) begin
        cnt_d   = 4'(DATA_DELAY - 1);
        state_d = (DATA_DELAY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready_o = (state_q == DONE);
    error_o      = (state_q == DONE) && lat_err;
    busy_o       = (state_q != IDLE);
    read_data_o  = rdata_q;
  end

endmodule

// File: tb/tb_dlx_latency_mem.sv
// Bench for dlx_latency_mem: four instances (DATA_DELAY 2, 3, 1, 15) checked against a
// word-level reference model held in an associative array.
module tb_dlx_latency_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        rnw;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        dr [4];
  logic        er [4];
  logic        bz [4];
  logic [31:0] rd [4];

  int n_checks = 0;
  int n_fail   = 0;
  int delay_of [4] = '{2, 3, 1, 15};

  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [4];
  bit          last_known [4];

  always #5 clk = ~clk;

  dlx_latency_mem #(.DATA_DELAY(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .readnotwrite_i(rnw), .address_i(addr),
    .write_data_i(wd), .byte_en_i(be), .data_ready_o(dr[0]), .read_data_o(rd[0]),
    .error_o(er[0]), .busy_o(bz[0]));
  dlx_latency_mem #(.DATA_DELAY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .readnotwrite_i(rnw), .address_i(addr),
    .write_data_i(wd), .byte_en_i(be), .data_ready_o(dr[1]), .read_data_o(rd[1]),
    .error_o(er[1]), .busy_o(bz[1]));
  dlx_latency_mem #(.DATA_DELAY(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .readnotwrite_i(rnw), .address_i(addr),
    .write_data_i(wd), .byte_en_i(be), .data_ready_o(dr[2]), .read_data_o(rd[2]),
    .error_o(er[2]), .busy_o(bz[2]));
  dlx_latency_mem #(.DATA_DELAY(15)) u_d15 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[3]), .readnotwrite_i(rnw), .address_i(addr),
    .write_data_i(wd), .byte_en_i(be), .data_ready_o(dr[3]), .read_data_o(rd[3]),
    .error_o(er[3]), .busy_o(bz[3]));

  // One complete access on instance k, compared against the model, which is then updated.
  task automatic access(input int k, input bit rd_not_wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    int          lat;
    int          key;
    bit          exp_err;
    bit          known;
    logic [31:0] exp_rd;
    logic [31:0] w;
    exp_err = (a % 4 != 0) || (a >= 32'h1000);
    key     = k * 1024 + int'(a[11:2]);
    exp_rd  = last_rd[k];
    known   = last_known[k];
    if (exp_err) begin
      exp_rd = '0;
      known  = 1'b1;
    end else if (rd_not_wr) begin
      known = ref_mem.exists(key);
      if (known) exp_rd = ref_mem[key];
    end

    @(negedge clk);
    en[k] = 1'b1; rnw = rd_not_wr; addr = a; wd = d; be = b;
    @(posedge clk); #1;
    en[k] = 1'b0; addr = $urandom; wd = $urandom; be = 4'($urandom); rnw = 1'($urandom);
    n_checks++;
    if (bz[k] !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_accept d%0d addr=%h: got %b expected 1", delay_of[k], a, bz[k]);
    end
    lat = 0;
    while (dr[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    // DATA_READY rises after edge t0+D-1, so it is first sampled by edge t0+D.
    n_checks++;
    if (lat + 1 != delay_of[k]) begin
      n_fail++; $display("FAIL latency d%0d addr=%h: got %0d expected %0d", delay_of[k], a, lat + 1, delay_of[k]);
    end
    n_checks++;
    if (er[k] !== exp_err) begin
      n_fail++; $display("FAIL error_flag d%0d addr=%h: got %b expected %b", delay_of[k], a, er[k], exp_err);
    end
    if (known) begin
      n_checks++;
      if (rd[k] !== exp_rd) begin
        n_fail++; $display("FAIL read_data d%0d addr=%h rnw=%b: got %h expected %h", delay_of[k], a, rd_not_wr, rd[k], exp_rd);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (dr[k] !== 1'b0 || bz[k] !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse d%0d addr=%h: got ready=%b busy=%b expected 0 0", delay_of[k], a, dr[k], bz[k]);
    end

    if (!exp_err && !rd_not_wr) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = d[8*i +: 8];
      if (ref_mem.exists(key) || b == 4'hF) ref_mem[key] = w;
    end
    last_rd[k]    = exp_rd;
    last_known[k] = known;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dr[k] !== 1'b0 || er[k] !== 1'b0 || bz[k] !== 1'b0 || rd[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state d%0d: got ready=%b err=%b busy=%b rdata=%h expected 0 0 0 0",
                 delay_of[k], dr[k], er[k], bz[k], rd[k]);
      end
      last_rd[k]    = '0;
      last_known[k] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    access(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 1'b1, 32'h10, 32'h0, 4'hF);
    n_checks++;
    if (rd[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_readback: got %h expected deadbeef", rd[0]);
    end
  endtask

  task automatic test_byte_mask();
    access(0, 1'b0, 32'h20, 32'h11223344, 4'hF);
    access(0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101);
    access(0, 1'b1, 32'h20, 32'h0, 4'h0);
    n_checks++;
    if (rd[0] !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_mask_readback: got %h expected 11bb33dd", rd[0]);
    end
    access(0, 1'b0, 32'h20, 32'h99999999, 4'h0);
    access(0, 1'b1, 32'h20, 32'h0, 4'h0);
  endtask

  task automatic test_errors();
    access(0, 1'b0, 32'h0,    32'hCAFEF00D, 4'hF);
    access(0, 1'b1, 32'h13,   32'h0, 4'hF);
    access(0, 1'b1, 32'h1000, 32'h0, 4'hF);
    access(0, 1'b0, 32'h1000, 32'h12345678, 4'hF);
    access(0, 1'b0, 32'h12,   32'h87654321, 4'hF);
    access(0, 1'b0, 32'hFFC,  32'h0F0F0F0F, 4'hF);
    access(0, 1'b1, 32'hFFC,  32'h0, 4'hF);
    access(0, 1'b1, 32'h10,   32'h0, 4'hF);
    access(0, 1'b1, 32'h0,    32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    int d;
    int pulses;
    int first;
    int second;
    int n;
    bit e_dr;
    bit e_bz;
    d = delay_of[1];
    pulses = 0; first = -1; second = -1;
    access(1, 1'b0, 32'h10, 32'h5A5A1234, 4'hF);
    @(negedge clk);
    en[1] = 1'b1; rnw = 1'b1; addr = 32'h10; be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      e_dr = (i % (d + 1)) == d - 1;
      e_bz = (i % (d + 1)) != d;
      n_checks++;
      if (dr[1] !== e_dr || bz[1] !== e_bz) begin
        n_fail++; $display("FAIL held_enable cycle %0d: got ready=%b busy=%b expected %b %b", i, dr[1], bz[1], e_dr, e_bz);
      end
      if (dr[1] === 1'b1) begin
        pulses++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    en[1] = 1'b0;
    n_checks++;
    if (pulses != 2 || second - first != d + 1) begin
      n_fail++; $display("FAIL held_enable_pulses: got %0d pulses gap %0d expected 2 gap %0d", pulses, second - first, d + 1);
    end
    n = 0;
    while (bz[1] !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (bz[1] !== 1'b0) begin
      n_fail++; $display("FAIL held_enable_drain: busy stuck got %b expected 0", bz[1]);
    end
    last_rd[1]    = ref_mem[1 * 1024 + 4];
    last_known[1] = 1'b1;
    access(1, 1'b1, 32'h10, 32'h0, 4'hF);
  endtask

  task automatic test_reset_abort();
    bit seen;
    access(0, 1'b0, 32'h40, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    en[0] = 1'b1; rnw = 1'b0; addr = 32'h40; wd = 32'hFFFFFFFF; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dr[0] !== 1'b0 || bz[0] !== 1'b0 || rd[0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_abort_state: got ready=%b busy=%b rdata=%h expected 0 0 0", dr[0], bz[0], rd[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dr[0] !== 1'b0 || bz[0] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reset_abort_quiet: got activity after reset expected none");
    end
    for (int k = 0; k < 4; k++) begin
      last_rd[k]    = '0;
      last_known[k] = 1'b1;
    end
    access(0, 1'b1, 32'h40, 32'h0, 4'hF);
  endtask

  task automatic test_random(input int k);
    int          j;
    int          r;
    logic [31:0] a;
    logic [31:0] idx;
    for (int i = 0; i < 9; i++) begin
      idx = (i == 8) ? 32'd1023 : 32'(i);
      access(k, 1'b0, idx * 4, $urandom, 4'hF);
    end
    for (int i = 0; i < 100; i++) begin
      j   = $urandom_range(0, 8);
      idx = (j == 8) ? 32'd1023 : 32'(j);
      r   = $urandom_range(0, 9);
      if (r == 0)      a = idx * 4 + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      else             a = idx * 4;
      access(k, 1'($urandom), a, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; rnw = 1'b1; addr = '0; wd = '0; be = '0;
    test_reset();
    test_basic();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_random(2);
    test_random(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
